router_slice_input_lock_ctrl: RTL
=================================

Name: router_slice_input_lock_ctrl

Overview:
- Per-input-port packet lock controller inside the router wrap slice, directly upstream of the ILCK flip-flop stage.
- Takes head/body/tail flits from the input buffer and requests the switch allocator with the head flit's destination.
- On grant, holds the port locked to that output until the tail flit passes, with credit-based flow control toward the downstream buffer.
- Produces `ilck`, the lock indicator that drives the ILCK flip-flop's D input.

Parameters:
- FLIT_W, 32, flit payload width; destination field is in_flit[DEST_W-1:0].
- DEST_W, 4, destination/output-port id width.
- MAX_CREDITS, 4, downstream buffer depth; credit counter reset value.
- CREDIT_W, 3, credit counter width; must satisfy 2^CREDIT_W > MAX_CREDITS.
- TIMEOUT_CYC, 15, grant-wait limit in cycles; used only with ILCK_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately.
- in_valid  in  1  upstream flit valid.
- in_ready  out  1  flit accepted when in_valid && in_ready.
- in_flit  in  FLIT_W  flit data.
- in_head  in  1  flit is a packet head.
- in_tail  in  1  flit is a packet tail; head and tail may both be 1.
- sa_req  out  1  switch allocator request.
- sa_dest  out  DEST_W  requested output port.
- sa_grant  in  1  allocator grant; sampled only in REQ.
- out_valid  out  1  registered flit valid toward the crossbar.
- out_flit  out  FLIT_W  registered flit data.
- credit_return  in  1  one credit returned by downstream.
- credit_cnt  out  CREDIT_W  current credits.
- ilck  out  1  port locked; feeds the ILCK flip-flop.
- err_orphan  out  1  one-cycle pulse: non-head flit dropped in IDLE.
- err_proto  out  1  one-cycle pulse: head flit seen while LOCKED, or credit overflow.

Behaviour:
- Reset (reset=0): state=IDLE, credit_cnt=MAX_CREDITS, dest register=0. All other outputs are 0: in_ready, sa_req, sa_dest, out_valid, out_flit, ilck, err_orphan, err_proto.
- Reset mid-packet abandons the packet. No flit is emitted; the downstream agent owns recovery.

FSM (states IDLE, REQ, LOCKED):
- IDLE:
  - in_ready = in_valid && !in_head, so orphan non-head flits are consumed and discarded, with err_orphan pulsed the next cycle.
  - in_valid && in_head: latch in_flit[DEST_W-1:0] into dest, go to REQ. The head flit is not consumed.
- REQ:
  - sa_req=1 and sa_dest=dest, both registered from state. in_ready=0.
  - sa_grant=1: go to LOCKED. ilck=1 from the next cycle.
- LOCKED:
  - ilck=1 and sa_req=0.
  - in_ready = (credit_cnt != 0).
  - The first accepted flit is the held head.
  - An accepted flit with in_tail=1 returns the FSM to IDLE; ilck=0 the following cycle.
  - A single-flit packet (head+tail) locks for exactly one transfer.
  - A head flit accepted after the first transfer is forwarded as a body flit, with err_proto pulsed.

Datapath and credits:
- Data path latency is 1 cycle. out_valid/out_flit register the accepted flit. out_valid=0 in cycles with no transfer; out_flit holds its last value.
- Credit update:
  - decrement on transfer;
  - increment on credit_return;
  - both in the same cycle: unchanged;
  - credit_return at MAX_CREDITS with no transfer: ignored, err_proto pulses.
- credit_cnt never underflows because in_ready is gated by credit_cnt != 0.

Optional Feature:
- Macro: ILCK_TIMEOUT_EN.
- Defined: a counter runs while in REQ and clears on entry to REQ. If it reaches TIMEOUT_CYC with no grant:
  - sa_req is deasserted for exactly one cycle (back-off);
  - err_proto pulses;
  - the counter restarts and sa_req reasserts.
  - A grant during the back-off cycle is ignored.
- Undefined: REQ waits for grant indefinitely, and no counter logic is synthesised.

Test Plan:
- Reset then idle: reset low 3 cycles, release → credit_cnt=4; ilck, sa_req, in_ready, out_valid all 0.
- 3-flit packet to dest 5, grant after 2 cycles:
  - sa_req=1 with sa_dest=5 for 2 cycles;
  - ilck=1 the cycle after grant;
  - three out_valid pulses, each 1 cycle after acceptance;
  - credit_cnt 4→1;
  - ilck=0 the cycle after the tail.
- Credit stall: 6-flit packet with no credit_return → in_ready drops after 4 transfers. One credit_return → exactly one more transfer.
- Simultaneous transfer + credit_return at credit_cnt=2 → stays 2. credit_return at 4 with no transfer → stays 4, err_proto=1 for one cycle.
- Body flit in IDLE → consumed, no out_valid, err_orphan=1 one cycle. Reset asserted while LOCKED mid-packet → ilck=0 and credit_cnt=4 immediately, without waiting for a clock edge.
- ILCK_TIMEOUT_EN with TIMEOUT_CYC=15 and no grant → sa_req low for 1 cycle after 15 cycles, then reasserts. A grant in the back-off cycle does not lock.

Source files
------------

// File: rtl/router_slice_input_lock_ctrl_if.sv
// router_slice_input_lock_ctrl_if: flit, allocator, credit and status signals of one router input port
interface router_slice_input_lock_ctrl_if #(
  parameter int FLIT_W   = 32,
  parameter int DEST_W   = 4,
  parameter int CREDIT_W = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [FLIT_W-1:0]   in_flit;
  logic                in_head;
  logic                in_tail;
  logic                sa_req;
  logic [DEST_W-1:0]   sa_dest;
  logic                sa_grant;
  logic                out_valid;
  logic [FLIT_W-1:0]   out_flit;
  logic                credit_return;
  logic [CREDIT_W-1:0] credit_cnt;
  logic                ilck;
  logic                err_orphan;
  logic                err_proto;
  // master: the surrounding slice (buffer, allocator, downstream credits)
  modport master (
    output in_valid, in_flit, in_head, in_tail, sa_grant, credit_return,
    input  in_ready, sa_req, sa_dest, out_valid, out_flit, credit_cnt, ilck, err_orphan, err_proto
  );
  // slave: the lock controller itself
  modport slave (
    input  in_valid, in_flit, in_head, in_tail, sa_grant, credit_return,
    output in_ready, sa_req, sa_dest, out_valid, out_flit, credit_cnt, ilck, err_orphan, err_proto
  );
endinterface

// File: rtl/router_slice_input_lock_ctrl.sv
// router_slice_input_lock_ctrl: per-input packet lock FSM with credit flow control; optional grant timeout under ILCK_TIMEOUT_EN
module router_slice_input_lock_ctrl #(
  parameter int FLIT_W      = 32,
  parameter int DEST_W      = 4,
  parameter int MAX_CREDITS = 4,
  parameter int CREDIT_W    = 3
`ifdef ILCK_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  router_slice_input_lock_ctrl_if.slave p
);
  typedef enum logic [1:0] {IDLE, REQ, LOCKED} state_t;
  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(MAX_CREDITS);
  state_t              state, state_nx;
  logic [DEST_W-1:0]   dest;
  logic [CREDIT_W-1:0] cnt;
  logic [FLIT_W-1:0]   flit_q;
  logic                vld_q, orphan_q, proto_q, seen;
  logic                rdy, req_on, xfer, drop, ovf, backoff, tmo;
  assign xfer = state == LOCKED && p.in_valid && rdy;
  assign drop = state == IDLE && p.in_valid && rdy;
  assign ovf  = p.credit_return && !xfer && cnt == CMAX;
  // next state and handshake decode; in_ready is forced low while reset is held
  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    req_on   = 1'b0;
    case (state)
      IDLE: begin
        rdy      = p.in_valid && !p.in_head;
        state_nx = p.in_valid && p.in_head ? REQ : IDLE;
      end
      REQ: begin
        req_on   = !backoff;
        state_nx = !backoff && p.sa_grant ? LOCKED : REQ;
      end
      LOCKED: begin
        rdy      = cnt != '0;
        state_nx = p.in_valid && rdy && p.in_tail ? IDLE : LOCKED;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // destination latch, output flit register, credit counter and error pulses
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dest     <= '0;
      cnt      <= CMAX;
      flit_q   <= '0;
      vld_q    <= 1'b0;
      orphan_q <= 1'b0;
      proto_q  <= 1'b0;
      seen     <= 1'b0;
    end else begin
      if (state == IDLE && p.in_valid && p.in_head) dest <= p.in_flit[DEST_W-1:0];
      if (xfer) flit_q <= p.in_flit;
      vld_q    <= xfer;
      orphan_q <= drop;
      proto_q  <= (xfer && p.in_head && seen) || ovf || tmo;
      seen     <= state == LOCKED && (seen || xfer);
      if (xfer && !p.credit_return) cnt <= cnt - 1'b1;
      else if (!xfer && p.credit_return && !ovf) cnt <= cnt + 1'b1;
    end
`ifdef ILCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == REQ && !backoff && !p.sa_grant && tcnt == TW'(TIMEOUT_CYC - 1);
  // grant-wait counter; a timeout drops sa_req for one back-off cycle, then the count restarts
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tcnt    <= '0;
      backoff <= 1'b0;
    end else if (state != REQ) begin
      tcnt    <= '0;
      backoff <= 1'b0;
    end else if (backoff) backoff <= 1'b0;
    else if (!p.sa_grant) begin
      tcnt    <= tmo ? '0 : tcnt + 1'b1;
      backoff <= tmo;
    end
`else
  assign tmo     = 1'b0;
  assign backoff = 1'b0;
`endif
  assign p.in_ready   = rdy && reset;
  assign p.sa_req     = req_on;
  assign p.sa_dest    = state == REQ ? dest : '0;
  assign p.ilck       = state == LOCKED;
  assign p.out_valid  = vld_q;
  assign p.out_flit   = flit_q;
  assign p.credit_cnt = cnt;
  assign p.err_orphan = orphan_q;
  assign p.err_proto  = proto_q;
endmodule
